mult_reduce_arbiter: RTL and testbench

Burst-locked round-robin arbiter that shares one `mult_reduce` instance between `NUM_REQ` conv1d channels. Each grant covers exactly one filter's worth of serial beats (`NUM_ELEMENTS`), so accumulations never interleave. An in-order ID FIFO routes each reduced result back to the channel that issued the burst. It sits between the per-channel p2s/weight-select stages and the shared multiplier, and between the multiplier output and the per-channel bias/ReLU stages.

---
 rtl/mult_reduce_arbiter_if.sv | 37 +++
 rtl/mult_reduce_arbiter.sv | 134 +++++++++++++
 tb/tb_mult_reduce_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_reduce_arbiter_if.sv
// Handshake bundle between the conv1d channels, the shared mult_reduce and the per-channel result stages.
// Latency: none, wires only.
// Backpressure: valid/ready on the beat path and the result path.
interface mult_reduce_arbiter_if #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]                 arb_valid_in;
    logic [NUM_REQ-1:0]                 arb_ready_in;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] arb_dataa_in;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] arb_datab_in;
    logic                               mr_valid_out;
    logic                               mr_ready_out;
    logic [DATA_WIDTH-1:0]              mr_dataa_out;
    logic [DATA_WIDTH-1:0]              mr_datab_out;
    logic                               mr_valid_in;
    logic                               mr_ready_in;
    logic [2*DATA_WIDTH-1:0]            mr_result_in;
    logic [NUM_REQ-1:0]                 res_valid_out;
    logic [NUM_REQ-1:0]                 res_ready_out;
    logic [2*DATA_WIDTH-1:0]            res_data_out;
    logic                               arb_err_out;

    modport master (
        output arb_valid_in, arb_dataa_in, arb_datab_in, mr_ready_out,
               mr_valid_in, mr_result_in, res_ready_out,
        input  arb_ready_in, mr_valid_out, mr_dataa_out, mr_datab_out,
               mr_ready_in, res_valid_out, res_data_out, arb_err_out
    );

    modport slave (
        input  arb_valid_in, arb_dataa_in, arb_datab_in, mr_ready_out,
               mr_valid_in, mr_result_in, res_ready_out,
        output arb_ready_in, mr_valid_out, mr_dataa_out, mr_datab_out,
               mr_ready_in, res_valid_out, res_data_out, arb_err_out
    );
endinterface

// File: rtl/mult_reduce_arbiter.sv
// Burst-locked round-robin share of one mult_reduce across NUM_REQ channels, with in-order result routing.
// Latency: one IDLE arbitration cycle per burst; beat and result paths are combinational.
// Backpressure: mr_ready_out gates the granted channel; res_ready_out of the head ID gates mr_ready_in.
module mult_reduce_arbiter #(
    parameter int DATA_WIDTH    = 12,
    parameter int NUM_REQ       = 4,
    parameter int NUM_ELEMENTS  = 5,
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_reduce_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam int AW = $clog2(ID_FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_ELEMENTS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant, grant_nxt;
    logic [GW-1:0] last_grant, last_grant_nxt;
    logic [GW-1:0] pick, cand;
    logic          pick_vld;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic [GW-1:0] id_mem [ID_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occupancy;
    logic [GW-1:0] head;
    logic          fifo_empty, fifo_full;
    logic          push, pop;
    logic          arb_err;

    assign head       = id_mem[rd_ptr];
    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == (AW+1)'(ID_FIFO_DEPTH));

    // Scan downward so the last hit is the first requester above last_grant.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = GW'((int'(last_grant) + i) % NUM_REQ);
            if (bus.arb_valid_in[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        bus.res_valid_out = '0;
        bus.mr_ready_in   = 1'b0;
        if (!fifo_empty) begin
            bus.res_valid_out[head] = bus.mr_valid_in;
            bus.mr_ready_in         = bus.res_ready_out[head];
        end
    end

    assign pop              = bus.mr_valid_in && bus.mr_ready_in;
    assign bus.res_data_out = bus.mr_result_in;
    assign bus.arb_err_out  = arb_err;

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        last_grant_nxt   = last_grant;
        beat_cnt_nxt     = beat_cnt;
        push             = 1'b0;
        bus.arb_ready_in = '0;
        bus.mr_valid_out = 1'b0;
        bus.mr_dataa_out = '0;
        bus.mr_datab_out = '0;
        case (state)
            IDLE: begin
                // A same-cycle pop frees the slot this push needs.
                if (pick_vld && (!fifo_full || pop)) begin
                    state_nxt      = BURST;
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    beat_cnt_nxt   = '0;
                    push           = 1'b1;
                end
            end
            BURST: begin
                bus.mr_valid_out        = bus.arb_valid_in[grant];
                bus.arb_ready_in[grant] = bus.mr_ready_out;
                bus.mr_dataa_out        = bus.arb_dataa_in[grant];
                bus.mr_datab_out        = bus.arb_datab_in[grant];
                if (bus.arb_valid_in[grant] && bus.mr_ready_out) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            arb_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
            if (bus.mr_valid_in && fifo_empty) arb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= pick;
    end
endmodule

// File: tb/tb_mult_reduce_arbiter.sv
// Directed + randomized bench for mult_reduce_arbiter against a queue-based burst/ID model.
// Outputs are checked at every negedge; inputs change 1 time unit after the posedge.
module tb_mult_reduce_arbiter;
    localparam int DW = 12;
    localparam int NR = 4;
    localparam int NE = 5;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_reduce_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    mult_reduce_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_ELEMENTS(NE), .ID_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;
    string phase = "init";

    // Reference model: who owns the multiplier, beats done, outstanding burst IDs.
    bit m_busy;
    int m_owner, m_beats, m_last;
    int m_q[$];
    bit m_err;

    // Observations taken from DUT outputs.
    int d_log[$];
    int r_log[$];
    logic [NR-1:0] prev_ar = '0;
    int hs_own, hs_other;

    function automatic logic bit_at(input logic [NR-1:0] v, input int i);
        logic [NR-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [DW-1:0] lane(input logic [NR*DW-1:0] v, input int i);
        logic [NR*DW-1:0] t;
        t = v >> (i * DW);
        return t[DW-1:0];
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int k = 0; k < NR; k++) if (bit_at(v, k)) r = k;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_last  = NR - 1;
        m_q.delete();
        m_err   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NR-1:0] e_ar, e_rv;
        logic e_mv, e_mr;
        logic [DW-1:0] e_da, e_db;
        e_ar = '0; e_rv = '0; e_mv = 1'b0; e_mr = 1'b0; e_da = '0; e_db = '0;
        if (m_busy) begin
            e_mv = bit_at(bus.arb_valid_in, m_owner);
            e_ar = NR'(bus.mr_ready_out) << m_owner;
            e_da = lane(bus.arb_dataa_in, m_owner);
            e_db = lane(bus.arb_datab_in, m_owner);
        end
        if (m_q.size() > 0) begin
            e_rv = NR'(bus.mr_valid_in) << m_q[0];
            e_mr = bit_at(bus.res_ready_out, m_q[0]);
        end
        chk({tag, "/arb_ready"},  64'(bus.arb_ready_in),  64'(e_ar));
        chk({tag, "/mr_valid"},   64'(bus.mr_valid_out),  64'(e_mv));
        chk({tag, "/mr_dataa"},   64'(bus.mr_dataa_out),  64'(e_da));
        chk({tag, "/mr_datab"},   64'(bus.mr_datab_out),  64'(e_db));
        chk({tag, "/mr_ready"},   64'(bus.mr_ready_in),   64'(e_mr));
        chk({tag, "/res_valid"},  64'(bus.res_valid_out), 64'(e_rv));
        chk({tag, "/res_data"},   64'(bus.res_data_out),  64'(bus.mr_result_in));
        chk({tag, "/err"},        64'(bus.arb_err_out),   64'(m_err));
        if (bus.arb_ready_in != '0 && prev_ar == '0) d_log.push_back(onehot_idx(bus.arb_ready_in));
        prev_ar = bus.arb_ready_in;
        if (bus.res_valid_out != '0 && bus.mr_ready_in) r_log.push_back(onehot_idx(bus.res_valid_out));
        if (bus.arb_valid_in[1] && bus.arb_ready_in[1]) hs_own++;
        if ((bus.arb_ready_in & 4'b1101) != '0) hs_other++;
    endtask

    task automatic model_update();
        bit pop, take;
        int w, c;
        pop  = (m_q.size() > 0) && bus.mr_valid_in && bit_at(bus.res_ready_out, m_q[0]);
        take = 1'b0;
        w    = -1;
        if (bus.mr_valid_in && m_q.size() == 0) m_err = 1'b1;
        if (!m_busy) begin
            if (bus.arb_valid_in != '0 && (m_q.size() < FD || pop)) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (m_last + k) % NR;
                    if (w < 0 && bit_at(bus.arb_valid_in, c)) w = c;
                end
                take    = 1'b1;
                m_busy  = 1'b1;
                m_owner = w;
                m_last  = w;
                m_beats = 0;
            end
        end else if (bit_at(bus.arb_valid_in, m_owner) && bus.mr_ready_out) begin
            m_beats++;
            if (m_beats == NE) m_busy = 1'b0;
        end
        if (pop) void'(m_q.pop_front());
        if (take) m_q.push_back(w);
    endtask

    task automatic step();
        bus.arb_dataa_in = (NR*DW)'({$urandom(), $urandom()});
        bus.arb_datab_in = (NR*DW)'({$urandom(), $urandom()});
        bus.mr_result_in = (2*DW)'($urandom());
        @(negedge clk);
        check_outputs(phase);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs({phase, "/in_reset"});
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_logs();
        d_log.delete();
        r_log.delete();
        hs_own   = 0;
        hs_other = 0;
    endtask

    initial begin
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        rst               = 1'b1;
        bus.arb_valid_in  = '0;
        bus.arb_dataa_in  = '0;
        bus.arb_datab_in  = '0;
        bus.mr_ready_out  = 1'b0;
        bus.mr_valid_in   = 1'b0;
        bus.mr_result_in  = '0;
        bus.res_ready_out = '0;
        #2;
        phase = "reset";
        do_reset();

        // Channel 2 alone: one idle cycle, then five beats, then its result.
        phase = "single";
        clear_logs();
        bus.arb_valid_in = 4'b0100;
        bus.mr_ready_out = 1'b1;
        repeat (6) step();
        bus.arb_valid_in = '0;
        step();
        chk("single/grants", 64'(d_log.size()), 64'(1));
        chk("single/grant_id", 64'((d_log.size() > 0) ? d_log[0] : -1), 64'(2));
        bus.mr_valid_in   = 1'b1;
        bus.res_ready_out = '1;
        step();
        bus.mr_valid_in   = 1'b0;
        chk("single/result_id", 64'((r_log.size() > 0) ? r_log[0] : -1), 64'(2));

        // All four channels requesting continuously from a fresh reset.
        phase = "contention";
        do_reset();
        clear_logs();
        bus.arb_valid_in  = '1;
        bus.res_ready_out = '1;
        repeat (30) begin
            bus.mr_valid_in = (m_q.size() > 0);
            step();
        end
        chk("contention/grants", 64'(d_log.size()), 64'(5));
        chk("contention/results", 64'(r_log.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("contention/grant%0d", i), 64'((d_log.size() > i) ? d_log[i] : -1), 64'(exp_ord[i]));
            chk($sformatf("contention/result%0d", i), 64'((r_log.size() > i) ? r_log[i] : -1), 64'(exp_ord[i]));
        end
        bus.arb_valid_in = '0;
        bus.mr_valid_in  = 1'b0;
        step();

        // Channel 1 wins next; toggling mr_ready_out stretches its burst.
        phase = "backpressure";
        clear_logs();
        bus.arb_valid_in = '1;
        for (int i = 0; i < 20 && hs_own < NE; i++) begin
            bus.mr_ready_out = (i % 2 == 0);
            bus.mr_valid_in  = (m_q.size() > 0);
            step();
        end
        chk("backpressure/handshakes", 64'(hs_own), 64'(NE));
        chk("backpressure/other_ready", 64'(hs_other), 64'(0));
        bus.arb_valid_in = '0;
        bus.mr_ready_out = 1'b1;
        repeat (3) begin
            bus.mr_valid_in = (m_q.size() > 0);
            step();
        end
        bus.mr_valid_in = 1'b0;

        // Two outstanding bursts fill the ID FIFO; a result handshake frees a slot.
        phase = "fifo_full";
        do_reset();
        clear_logs();
        bus.arb_valid_in = '1;
        repeat (14) step();
        chk("fifo_full/stalled_grants", 64'(d_log.size()), 64'(2));
        bus.mr_valid_in = 1'b1;
        step();
        bus.mr_valid_in = 1'b0;
        step();
        chk("fifo_full/third_grant", 64'(d_log.size()), 64'(3));
        chk("fifo_full/third_id", 64'((d_log.size() > 2) ? d_log[2] : -1), 64'(2));
        bus.arb_valid_in = 4'b0100;
        repeat (4) step();
        bus.arb_valid_in = '0;
        step();
        repeat (3) begin
            bus.mr_valid_in = (m_q.size() > 0);
            step();
        end
        bus.mr_valid_in = 1'b0;

        // Head result for channel 3 is held off by its own ready, then an orphan result.
        phase = "routing";
        do_reset();
        clear_logs();
        bus.arb_valid_in = 4'b1000;
        repeat (6) step();
        bus.arb_valid_in  = '0;
        step();
        bus.mr_valid_in   = 1'b1;
        bus.res_ready_out = 4'b0111;
        repeat (3) step();
        chk("routing/held", 64'(r_log.size()), 64'(0));
        bus.res_ready_out = '1;
        step();
        bus.mr_valid_in = 1'b0;
        chk("routing/released", 64'(r_log.size()), 64'(1));
        chk("routing/result_id", 64'((r_log.size() > 0) ? r_log[0] : -1), 64'(3));
        bus.mr_valid_in = 1'b1;
        step();
        bus.mr_valid_in = 1'b0;
        chk("routing/err_set", 64'(bus.arb_err_out), 64'(1));
        step();

        // Reset lands after beat 3 of channel 1's burst.
        phase = "midreset";
        clear_logs();
        bus.arb_valid_in = 4'b0010;
        repeat (4) step();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset/async");
        chk("midreset/arb_ready", 64'(bus.arb_ready_in), 64'(0));
        chk("midreset/err_cleared", 64'(bus.arb_err_out), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
        bus.arb_valid_in = 4'b0011;
        repeat (2) step();
        chk("midreset/first_grant", 64'((d_log.size() > 0) ? d_log[0] : -1), 64'(0));
        bus.arb_valid_in = 4'b0001;
        repeat (4) step();
        bus.arb_valid_in = '0;
        step();
        repeat (2) begin
            bus.mr_valid_in = (m_q.size() > 0);
            step();
        end

        phase = "random";
        repeat (400) begin
            bus.arb_valid_in  = NR'($urandom());
            bus.mr_ready_out  = 1'($urandom_range(0, 1));
            bus.res_ready_out = NR'($urandom());
            bus.mr_valid_in   = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            step();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
